jump_seq_ctrl: RTL and testbench
================================

# jump_seq_ctrl

Hardwired micro-step sequencer for the CPU datapath. It issues the instruction fetch (T0–T2) and the control-transfer instructions `jal`, `jr` and `br`, one control word per clock. It replaces hand-driven per-step control with a parametrised FSM that waits on memory, picks the link register, and evaluates branch conditions. It sits between the IR/CON logic and the datapath control inputs.

## Interface
Parameters:
- `OPC_W`, 5: opcode width (IR[31:27]).
- `LINK_REG`, 15: register index written by `jal`.
- `OPC_JAL`, 5'b10101: `jal` opcode.
- `OPC_JR`, 5'b10100: `jr` opcode.
- `OPC_BR`, 5'b10011: `br` opcode.

Ports:
- `clock` in 1: single clock. All state changes on the rising edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled in IDLE and at the end of each instruction.
- `mem_ready` in 1: memory read data valid.
- `opcode` in OPC_W: IR opcode field.
- `con` in 1: CON flip-flop output.
- `PCout`, `IncPC`, `MARin`, `memRead`, `MDRin`, `MDRout`, `IRin` out 1: fetch controls.
- `Gra`, `Rout`, `PCin`, `CONin`, `Yin`, `Cout`, `ADD`, `Zin`, `Zlowout` out 1: execute controls.
- `link_wr` out 1: write enable for the link register.
- `link_sel` out 4: link register index, always `LINK_REG`.
- `busy` out 1: high in any state other than IDLE and ILLEGAL.
- `illegal` out 1: unsupported opcode trapped.
- `step` out 4: current T-step number (0–6); 0 in IDLE and ILLEGAL.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, ILLEGAL.
- Outputs are Moore, decoded from the state register. Every control output not listed for a state is 0.
- IDLE: `start`=1 → T0.
- T0: `PCout`, `MARin`, `IncPC` → T1.
- T1: `memRead`, `MDRin`. Stays in T1 while `mem_ready`=0; → T2 when `mem_ready`=1.
- T2: `MDRout`, `IRin` → T3.
- T3 decodes `opcode` (IR loaded at the end of T2):
  - `jal`: `PCout`, `link_wr` → T4.
  - `jr`: `Gra`, `Rout`, `PCin` → END.
  - `br`: `Gra`, `Rout`, `CONin` → T4.
  - any other opcode → ILLEGAL. The T3 control word is all-zero.
- T4:
  - `jal`: `Gra`, `Rout`, `PCin` → END.
  - `br`: `PCout`, `Yin` → T5.
- T5 (br): `Cout`, `ADD`, `Zin` → T6.
- T6 (br): `Zlowout`. `PCin` is asserted only if `con`=1 → END.
- END is the transition out of the last step: → T0 if `start`=1, else IDLE. There is no dead cycle between back-to-back instructions.
- The executing opcode is latched into an internal register at the T3 edge. A later change on `opcode` does not alter the sequence in progress.
- ILLEGAL: `illegal`=1, all controls 0. Held until `clear`.
- `clear`=1 at an edge → IDLE, from any state, including mid-T1 wait and ILLEGAL.
- Reset values: state IDLE; all outputs 0 except `link_sel`=`LINK_REG`.

## Timing
- Fetch latency is 3 cycles plus memory wait cycles.
- Per-instruction cycle counts, excluding the T1 wait: `jr` 4, `jal` 5, `br` 7.
- `con` is sampled combinationally in T6. CON is loaded at the T3→T4 edge, so it is stable by T6.
- `start` is ignored outside IDLE and the END decision.
- `mem_ready` is ignored outside T1.
- `clear` has priority over every other input.

## Configuration
- `JSEQ_BRANCH_EN` defined: `br` is supported as described above (states T5/T6 exist).
- `JSEQ_BRANCH_EN` undefined:
  - `OPC_BR` decodes as illegal at T3.
  - States T5/T6 and the `con` logic are removed.
  - `CONin`, `Yin`, `Cout`, `ADD`, `Zin` and `Zlowout` are tied to 0.

## Test plan
- **Reset:** pulse `clear`, `start`=0 → state IDLE, all outputs 0, `link_sel`=15, `busy`=0.
- **jal fetch and execute:** `start`=1, `mem_ready`=1, opcode 5'b10101 (IR 0xAB000000) → steps 0,1,2,3,4. `link_wr` and `PCout` assert in T3; `PCin`, `Gra` and `Rout` assert in T4; T0 follows immediately.
- **Memory stall:** `mem_ready` held 0 for 3 cycles in T1 → `step`=1 and `memRead`/`MDRin` held for 4 cycles total, then T2.
- **Branch, both outcomes:** `br` with `con`=1 → `PCin` asserted in T6. Repeat with `con`=0 → `PCin` stays 0 through T6. Without the macro the same opcode → `illegal`=1 after T3.
- **Illegal opcode and clear:** opcode 5'b00000 → ILLEGAL with `illegal`=1 held. Then `clear` → IDLE. Separately, `clear` asserted mid-T1 → IDLE on the next edge.

Source files
------------

// File: rtl/jump_seq_ctrl.sv
// Fetch/jal/jr/br micro-step sequencer: one control word per clock, Moore-decoded from state (T3 word from live IR, T6 PCin from con).
// Latency: fetch 3 cycles + memory wait; jr 4, jal 5, br 7 cycles per instruction. Stalls in T1 while mem_ready is low.
// Optional branch support: define JSEQ_BRANCH_EN to enable br (T5/T6); otherwise br traps as illegal.
module jump_seq_ctrl #(
    parameter int                 OPC_W    = 5,
    parameter int                 LINK_REG = 15,
    parameter logic [OPC_W-1:0]   OPC_JAL  = 5'b10101,
    parameter logic [OPC_W-1:0]   OPC_JR   = 5'b10100,
    parameter logic [OPC_W-1:0]   OPC_BR   = 5'b10011
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             mem_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic             con,
    output logic             PCout,
    output logic             IncPC,
    output logic             MARin,
    output logic             memRead,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Gra,
    output logic             Rout,
    output logic             PCin,
    output logic             CONin,
    output logic             Yin,
    output logic             Cout,
    output logic             ADD,
    output logic             Zin,
    output logic             Zlowout,
    output logic             link_wr,
    output logic [3:0]       link_sel,
    output logic             busy,
    output logic             illegal,
    output logic [3:0]       step
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
`ifdef JSEQ_BRANCH_EN
        S_T5,
        S_T6,
`endif
        S_ILLEGAL
    } state_t;

    state_t           state;
    state_t           end_state;
    logic [OPC_W-1:0] op_q;
    logic             op_br;

`ifdef JSEQ_BRANCH_EN
    assign op_br = (opcode == OPC_BR);
`else
    logic unused_cfg;
    assign op_br      = 1'b0;
    assign unused_cfg = con ^ (opcode == OPC_BR);
`endif

    // Back-to-back instructions skip IDLE when start is already high.
    assign end_state = start ? S_T0 : S_IDLE;
    assign link_sel  = 4'(LINK_REG);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1:   if (mem_ready) state <= S_T2;
                S_T2:   state <= S_T3;
                S_T3: begin
                    op_q <= opcode;
                    if (opcode == OPC_JR)
                        state <= end_state;
                    else if (opcode == OPC_JAL || op_br)
                        state <= S_T4;
                    else
                        state <= S_ILLEGAL;
                end
`ifdef JSEQ_BRANCH_EN
                S_T4:   state <= (op_q == OPC_BR) ? S_T5 : end_state;
                S_T5:   state <= S_T6;
                S_T6:   state <= end_state;
`else
                S_T4:   state <= end_state;
`endif
                S_ILLEGAL: state <= S_ILLEGAL;
                default:   state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout   = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        memRead = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Gra     = 1'b0;
        Rout    = 1'b0;
        PCin    = 1'b0;
        CONin   = 1'b0;
        Yin     = 1'b0;
        Cout    = 1'b0;
        ADD     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        link_wr = 1'b0;
        step    = 4'd0;
        case (state)
            S_T0: begin
                step  = 4'd0;
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            S_T1: begin
                step    = 4'd1;
                memRead = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                step   = 4'd2;
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                // IR was written at the T2 edge, so decode the live opcode here.
                step = 4'd3;
                if (opcode == OPC_JAL) begin
                    PCout   = 1'b1;
                    link_wr = 1'b1;
                end else if (opcode == OPC_JR) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end else if (op_br) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
`ifdef JSEQ_BRANCH_EN
                    CONin = 1'b1;
`endif
                end
            end
            S_T4: begin
                step = 4'd4;
                if (op_q == OPC_JAL) begin
                    Gra  = 1'b1;
                    Rout = 1'b1;
                    PCin = 1'b1;
                end
`ifdef JSEQ_BRANCH_EN
                else if (op_q == OPC_BR) begin
                    PCout = 1'b1;
                    Yin   = 1'b1;
                end
`endif
            end
`ifdef JSEQ_BRANCH_EN
            S_T5: begin
                step = 4'd5;
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_T6: begin
                step    = 4'd6;
                Zlowout = 1'b1;
                PCin    = con;
            end
`endif
            default: ;
        endcase
    end

    assign busy    = (state != S_IDLE) && (state != S_ILLEGAL);
    assign illegal = (state == S_ILLEGAL);

endmodule

// File: tb/tb_jump_seq_ctrl.sv
// Scoreboard bench for jump_seq_ctrl: expected per-cycle control words are queued when an instruction is issued
// and popped/compared at each falling edge. Build with or without JSEQ_BRANCH_EN.
module tb_jump_seq_ctrl;

    localparam logic [4:0] OP_JAL = 5'b10101;
    localparam logic [4:0] OP_JR  = 5'b10100;
    localparam logic [4:0] OP_BR  = 5'b10011;

    localparam logic [16:0] M_PCOUT   = 17'h10000;
    localparam logic [16:0] M_INCPC   = 17'h08000;
    localparam logic [16:0] M_MARIN   = 17'h04000;
    localparam logic [16:0] M_MEMREAD = 17'h02000;
    localparam logic [16:0] M_MDRIN   = 17'h01000;
    localparam logic [16:0] M_MDROUT  = 17'h00800;
    localparam logic [16:0] M_IRIN    = 17'h00400;
    localparam logic [16:0] M_GRA     = 17'h00200;
    localparam logic [16:0] M_ROUT    = 17'h00100;
    localparam logic [16:0] M_PCIN    = 17'h00080;
    localparam logic [16:0] M_CONIN   = 17'h00040;
    localparam logic [16:0] M_YIN     = 17'h00020;
    localparam logic [16:0] M_COUT    = 17'h00010;
    localparam logic [16:0] M_ADD     = 17'h00008;
    localparam logic [16:0] M_ZIN     = 17'h00004;
    localparam logic [16:0] M_ZLOWOUT = 17'h00002;
    localparam logic [16:0] M_LINKWR  = 17'h00001;

    logic       clock = 1'b0;
    logic       clear, start, mem_ready, con;
    logic [4:0] opcode;
    logic       PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin;
    logic       Gra, Rout, PCin, CONin, Yin, Cout, ADD, Zin, Zlowout, link_wr;
    logic [3:0] link_sel, step;
    logic       busy, illegal;

    int n_vec  = 0;
    int n_miss = 0;

    logic [26:0] exp_q[$];
    logic [4:0]  drv_op[$];
    logic        drv_mr[$];
    logic        drv_st[$];

    always #5 clock = ~clock;

    jump_seq_ctrl dut (
        .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready),
        .opcode(opcode), .con(con),
        .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .memRead(memRead),
        .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Gra(Gra), .Rout(Rout), .PCin(PCin), .CONin(CONin), .Yin(Yin),
        .Cout(Cout), .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout),
        .link_wr(link_wr), .link_sel(link_sel), .busy(busy),
        .illegal(illegal), .step(step)
    );

    wire [26:0] obs = {illegal, busy, step, link_sel,
                       PCout, IncPC, MARin, memRead, MDRin, MDRout, IRin,
                       Gra, Rout, PCin, CONin, Yin, Cout, ADD, Zin, Zlowout, link_wr};

    function automatic logic [26:0] mk(input logic ill, input logic bsy,
                                       input logic [3:0] stp, input logic [16:0] ctl);
        return {ill, bsy, stp, 4'd15, ctl};
    endfunction

    task automatic check_vec(input string tag, input logic [26:0] got, input logic [26:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic add(input logic [26:0] e, input logic [4:0] op, input logic mr, input logic st);
        exp_q.push_back(e);
        drv_op.push_back(op);
        drv_mr.push_back(mr);
        drv_st.push_back(st);
    endtask

    function automatic logic [4:0] r5();
        return 5'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    // Called so that the DUT is in T0 at the next falling edge.
    task automatic run_instr(input logic [4:0] op, input logic conv, input int stall,
                             input logic start_next, input string nm);
        int  n = 0;
        bit  trapped = 0;
        logic [26:0] e;
        con = conv;
        add(mk(0, 1, 0, M_PCOUT | M_MARIN | M_INCPC), r5(), r1(), r1());
        for (int j = 0; j <= stall; j++)
            add(mk(0, 1, 1, M_MEMREAD | M_MDRIN), r5(), (j == stall), r1());
        add(mk(0, 1, 2, M_MDROUT | M_IRIN), op, r1(), r1());
        if (op == OP_JAL) begin
            add(mk(0, 1, 3, M_PCOUT | M_LINKWR), op, r1(), r1());
            add(mk(0, 1, 4, M_GRA | M_ROUT | M_PCIN), r5(), r1(), start_next);
        end else if (op == OP_JR) begin
            add(mk(0, 1, 3, M_GRA | M_ROUT | M_PCIN), op, r1(), start_next);
`ifdef JSEQ_BRANCH_EN
        end else if (op == OP_BR) begin
            add(mk(0, 1, 3, M_GRA | M_ROUT | M_CONIN), op, r1(), r1());
            add(mk(0, 1, 4, M_PCOUT | M_YIN), r5(), r1(), r1());
            add(mk(0, 1, 5, M_COUT | M_ADD | M_ZIN), r5(), r1(), r1());
            add(mk(0, 1, 6, M_ZLOWOUT | (conv ? M_PCIN : 17'h0)), r5(), r1(), start_next);
`endif
        end else begin
            trapped = 1;
            add(mk(0, 1, 3, 17'h0), op, r1(), r1());
            for (int j = 0; j < 3; j++)
                add(mk(1, 0, 0, 17'h0), r5(), r1(), 1'b1);
        end
        while (exp_q.size() > 0) begin
            @(negedge clock);
            e = exp_q.pop_front();
            n++;
            check_vec($sformatf("%s.c%0d", nm, n), obs, e);
            opcode    = drv_op.pop_front();
            mem_ready = drv_mr.pop_front();
            start     = drv_st.pop_front();
        end
        if (trapped) begin
            clear = 1'b1;
            @(negedge clock);
            check_vec({nm, ".clr"}, obs, mk(0, 0, 0, 17'h0));
            clear = 1'b0;
            start = start_next;
        end
    endtask

    task automatic idle_start(input string nm);
        @(negedge clock);
        check_vec(nm, obs, mk(0, 0, 0, 17'h0));
        start = 1'b1;
    endtask

    initial begin
        logic [4:0] op;
        clear = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = 5'd0; con = 1'b0;
        repeat (2) @(negedge clock);
        check_vec("reset", obs, mk(0, 0, 0, 17'h0));
        clear = 1'b0;

        idle_start("idle0");
        run_instr(OP_JAL, 1'b0, 0, 1'b1, "jal");
        run_instr(OP_JR,  1'b1, 0, 1'b1, "jr_b2b");
        run_instr(OP_JAL, 1'b0, 3, 1'b0, "stall");

        idle_start("idle1");
        run_instr(OP_BR, 1'b1, 1, 1'b1, "br_c1");
        run_instr(OP_BR, 1'b0, 0, 1'b0, "br_c0");

        idle_start("idle2");
        run_instr(5'b00000, 1'b0, 0, 1'b0, "illegal");

        // Clear while waiting on memory.
        idle_start("idle3");
        @(negedge clock);
        check_vec("clr_t0", obs, mk(0, 1, 0, M_PCOUT | M_MARIN | M_INCPC));
        mem_ready = 1'b0;
        @(negedge clock);
        check_vec("clr_t1", obs, mk(0, 1, 1, M_MEMREAD | M_MDRIN));
        clear = 1'b1;
        @(negedge clock);
        check_vec("clr_mid", obs, mk(0, 0, 0, 17'h0));
        clear = 1'b0;
        start = 1'b0;

        idle_start("idle4");
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0:       op = OP_JAL;
                1:       op = OP_JR;
                2:       op = OP_BR;
                default: op = r5();
            endcase
            run_instr(op, r1(), $urandom_range(0, 2), (k != 7), $sformatf("rnd%0d", k));
        end
        idle_start("idle_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
